// File: rtl/lcd_bus_reader_pkg.sv
// Shared types and constants for the HD44780 read-side bus engine.
package lcd_bus_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_E_HIGH,
        ST_E_LOW,
        ST_RESP
    } state_t;

    localparam logic RS_CMD   = 1'b0;
    localparam logic RS_DATA  = 1'b1;
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam int   BF_BIT   = 7;
    localparam int   AC_MSB   = 6;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_bus_reader_if.sv
// Request/response handshake plus LCD pad signals of the read engine.
interface lcd_bus_reader_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rs;
    logic       req_poll;
    logic [7:0] lcd_data_i;
    logic       lcd_rw;
    logic       lcd_rs;
    logic       lcd_e;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_busy;
    logic [6:0] rsp_addr;
    logic       rsp_timeout;

    modport master (
        output req_valid, req_rs, req_poll, lcd_data_i,
        input  req_ready, lcd_rw, lcd_rs, lcd_e,
        input  rsp_valid, rsp_data, rsp_busy, rsp_addr, rsp_timeout
    );

    modport slave (
        input  req_valid, req_rs, req_poll, lcd_data_i,
        output req_ready, lcd_rw, lcd_rs, lcd_e,
        output rsp_valid, rsp_data, rsp_busy, rsp_addr, rsp_timeout
    );
endinterface

// File: rtl/lcd_bus_reader_phase_timer.sv
// Loadable down-counter shared by the SETUP / E_HIGH / E_LOW phases.
module lcd_bus_reader_phase_timer #(
    parameter int W = 5
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_count,
    output logic         o_done
);
    logic [W-1:0] r_count;
    logic         r_active;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count  <= '0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_count  <= i_load_val;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_count == '0) r_active <= 1'b0;
            else               r_count  <= r_count - 1'b1;
        end
    end

    // Loading N-1 gives a phase of exactly N cycles ending on this pulse.
    assign o_done  = r_active && (r_count == '0);
    assign o_count = r_count;
endmodule

// File: rtl/lcd_bus_reader.sv
// Read-side engine for an HD44780 8-bit bus: status/data reads with optional
// busy-flag polling. All bus and response outputs are registered.
//
//   state     | meaning
//   ST_IDLE   | ready for a request
//   ST_SETUP  | RS/RW driven, E low, address setup
//   ST_E_HIGH | E high, pad sampled at the configured index
//   ST_E_LOW  | E low hold; then poll again or respond
//   ST_RESP   | one-cycle response pulse
module lcd_bus_reader
    import lcd_bus_reader_pkg::*;
#(
    parameter int T_AS     = 4,
    parameter int T_EH     = 25,
    parameter int T_DDR    = 20,
    parameter int T_EL     = 25,
    parameter int POLL_MAX = 4096
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    lcd_bus_reader_if.slave  bus
);
    localparam int             T_MAX      = max3(T_AS, T_EH, T_EL);
    localparam int             PW         = $clog2(T_MAX + 1);
    localparam int             CW         = $clog2(POLL_MAX + 1);
    localparam logic [PW-1:0]  SAMPLE_CNT = PW'(T_EH - T_DDR);
    localparam logic [CW-1:0]  POLL_LIM   = CW'(POLL_MAX);

    state_t         r_state, w_next;
    logic           r_rs, r_poll;
    logic [7:0]     r_sample;
    logic [CW-1:0]  r_reads;

    logic           w_accept, w_sample, w_poll_again, w_load, w_done;
    logic [PW-1:0]  w_load_val, w_count;
    logic           w_lcd_e, w_lcd_rw, w_lcd_rs, w_ready, w_rs_cur;

    logic           r_lcd_e, r_lcd_rw, r_lcd_rs, r_ready;
    logic           r_rsp_valid, r_rsp_busy, r_rsp_timeout;
    logic [7:0]     r_rsp_data;
    logic [6:0]     r_rsp_addr;

    assign w_accept     = (r_state == ST_IDLE) && r_ready && bus.req_valid;
    assign w_sample     = (r_state == ST_E_HIGH) && (w_count == SAMPLE_CNT);
    assign w_poll_again = r_poll && r_sample[BF_BIT] && (r_reads < POLL_LIM);

    lcd_bus_reader_phase_timer #(.W(PW)) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_count    (w_count),
        .o_done     (w_done)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next = ST_SETUP;
            ST_SETUP:  if (w_done)   w_next = ST_E_HIGH;
            ST_E_HIGH: if (w_done)   w_next = ST_E_LOW;
            ST_E_LOW:  if (w_done)   w_next = w_poll_again ? ST_SETUP : ST_RESP;
            ST_RESP:                 w_next = ST_IDLE;
            default:                 w_next = ST_IDLE;
        endcase
    end

    // The phase timer is reloaded on every phase entry, including poll re-entry into SETUP.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        if (w_next != r_state) begin
            case (w_next)
                ST_SETUP:  begin w_load = 1'b1; w_load_val = PW'(T_AS - 1); end
                ST_E_HIGH: begin w_load = 1'b1; w_load_val = PW'(T_EH - 1); end
                ST_E_LOW:  begin w_load = 1'b1; w_load_val = PW'(T_EL - 1); end
                default:   ;
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered pins line up with the state.
    always_comb begin
        w_lcd_e  = 1'b0;
        w_lcd_rw = RW_WRITE;
        w_lcd_rs = RS_CMD;
        w_ready  = 1'b0;
        w_rs_cur = (r_state == ST_IDLE) ? bus.req_rs : r_rs;
        case (w_next)
            ST_IDLE:   w_ready = 1'b1;
            ST_SETUP,
            ST_E_LOW:  begin w_lcd_rw = RW_READ; w_lcd_rs = w_rs_cur; end
            ST_E_HIGH: begin w_lcd_e = 1'b1; w_lcd_rw = RW_READ; w_lcd_rs = w_rs_cur; end
            default:   ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rs          <= RS_CMD;
            r_poll        <= 1'b0;
            r_sample      <= '0;
            r_reads       <= '0;
            r_lcd_e       <= 1'b0;
            r_lcd_rw      <= RW_WRITE;
            r_lcd_rs      <= RS_CMD;
            r_ready       <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_busy    <= 1'b0;
            r_rsp_addr    <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rs    <= bus.req_rs;
                r_poll  <= bus.req_poll && (bus.req_rs == RS_CMD);
                r_reads <= '0;
            end else if (w_sample) begin
                r_sample <= bus.lcd_data_i;
                r_reads  <= r_reads + 1'b1;
            end
            r_lcd_e     <= w_lcd_e;
            r_lcd_rw    <= w_lcd_rw;
            r_lcd_rs    <= w_lcd_rs;
            r_ready     <= w_ready;
            r_rsp_valid <= (w_next == ST_RESP);
            if (w_next == ST_RESP) begin
                r_rsp_data    <= r_sample;
                r_rsp_busy    <= (r_rs == RS_DATA) ? 1'b0 : r_sample[BF_BIT];
                r_rsp_addr    <= (r_rs == RS_DATA) ? 7'd0 : r_sample[AC_MSB:0];
                r_rsp_timeout <= r_poll && r_sample[BF_BIT];
            end
        end
    end

    assign bus.lcd_e       = r_lcd_e;
    assign bus.lcd_rw      = r_lcd_rw;
    assign bus.lcd_rs      = r_lcd_rs;
    assign bus.req_ready   = r_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.rsp_busy    = r_rsp_busy;
    assign bus.rsp_addr    = r_rsp_addr;
    assign bus.rsp_timeout = r_rsp_timeout;
endmodule

// File: tb/tb_lcd_bus_reader.sv
// Directed bench for lcd_bus_reader with default timing and POLL_MAX=4.
module tb_lcd_bus_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lcd_bus_reader_if bus();

    lcd_bus_reader #(.POLL_MAX(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    int         m_lat, m_pulses, m_ehigh, m_first_e, m_rs_bad, m_rw_bad;
    logic [7:0] m_data;
    logic [6:0] m_addr;
    logic       m_busy, m_to, m_rdy_rsp, m_rw_rsp, m_rs_rsp, m_rdy_after, m_v_after;

    logic [7:0] pad_seq [4];
    int         npad = 0;
    int         chg_cyc = -1;
    logic [7:0] chg_val = 8'h00;
    logic       hold_valid = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && bus.req_ready !== 1'b1; i++) tick();
    endtask

    // Accept happens at the edge inside this task; on return we observe cycle 1.
    task automatic issue(input logic rs, input logic poll);
        bus.req_rs    = rs;
        bus.req_poll  = poll;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        bus.req_rs    = ~rs;
        bus.req_poll  = ~poll;
    endtask

    task automatic run_txn(input logic exp_rs, input int budget);
        int   cyc;
        logic prev_e;
        m_lat = -1; m_pulses = 0; m_ehigh = 0; m_first_e = -1; m_rs_bad = 0; m_rw_bad = 0;
        m_data = 'x; m_addr = 'x; m_busy = 'x; m_to = 'x;
        m_rdy_rsp = 'x; m_rw_rsp = 'x; m_rs_rsp = 'x; m_rdy_after = 'x; m_v_after = 'x;
        prev_e = 1'b0;
        cyc = 1;
        while (cyc <= budget && m_lat < 0) begin
            if (chg_cyc == cyc) bus.lcd_data_i = chg_val;
            if (npad > 0 && prev_e && !bus.lcd_e)
                bus.lcd_data_i = pad_seq[(m_pulses < npad - 1) ? m_pulses : npad - 1];
            if (bus.lcd_e === 1'b1 && !prev_e) begin
                m_pulses++;
                if (m_first_e < 0) m_first_e = cyc;
            end
            if (bus.lcd_e === 1'b1) m_ehigh++;
            if (bus.rsp_valid === 1'b1) begin
                m_lat = cyc; m_data = bus.rsp_data; m_addr = bus.rsp_addr;
                m_busy = bus.rsp_busy; m_to = bus.rsp_timeout;
                m_rdy_rsp = bus.req_ready; m_rw_rsp = bus.lcd_rw; m_rs_rsp = bus.lcd_rs;
            end else begin
                if (bus.lcd_rs !== exp_rs) m_rs_bad++;
                if (bus.lcd_rw !== 1'b1)   m_rw_bad++;
            end
            if (hold_valid) bus.req_valid = (cyc < 40);
            prev_e = (bus.lcd_e === 1'b1);
            tick();
            cyc++;
        end
        bus.req_valid = 1'b0;
        if (m_lat >= 0) begin
            m_rdy_after = bus.req_ready;
            m_v_after   = bus.rsp_valid;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        total++;
        if ({bus.req_ready, bus.lcd_e, bus.lcd_rw, bus.lcd_rs, bus.rsp_valid, bus.rsp_data,
             bus.rsp_busy, bus.rsp_addr, bus.rsp_timeout} !== 23'd0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", {bus.req_ready, bus.lcd_e, bus.lcd_rw,
                bus.lcd_rs, bus.rsp_valid, bus.rsp_data, bus.rsp_busy, bus.rsp_addr, bus.rsp_timeout});
        end
        rst_n = 1'b1;
        tick();
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset: got %b want 1", bus.req_ready); end
    endtask

    task automatic test_status_read();
        bus.lcd_data_i = 8'h25;
        wait_ready();
        issue(1'b0, 1'b0);
        run_txn(1'b0, 100);
        total++; if (m_lat != 55)        begin bad++; $display("FAIL status_latency: got %0d want 55", m_lat); end
        total++; if (m_pulses != 1)      begin bad++; $display("FAIL status_pulses: got %0d want 1", m_pulses); end
        total++; if (m_ehigh != 25)      begin bad++; $display("FAIL status_e_high: got %0d want 25", m_ehigh); end
        total++; if (m_first_e != 5)     begin bad++; $display("FAIL status_e_rise_cycle: got %0d want 5", m_first_e); end
        total++; if (m_data !== 8'h25)   begin bad++; $display("FAIL status_data: got %h want 25", m_data); end
        total++; if (m_busy !== 1'b0)    begin bad++; $display("FAIL status_busy: got %b want 0", m_busy); end
        total++; if (m_addr !== 7'h25)   begin bad++; $display("FAIL status_addr: got %h want 25", m_addr); end
        total++; if (m_to !== 1'b0)      begin bad++; $display("FAIL status_timeout: got %b want 0", m_to); end
        total++; if (m_rs_bad != 0)      begin bad++; $display("FAIL status_rs_low: got %0d bad cycles want 0", m_rs_bad); end
        total++; if (m_rw_bad != 0)      begin bad++; $display("FAIL status_rw_high: got %0d bad cycles want 0", m_rw_bad); end
        total++; if ({m_rdy_rsp, m_rw_rsp, m_rs_rsp} !== 3'b000)
            begin bad++; $display("FAIL status_resp_cycle_pins: got %b want 000", {m_rdy_rsp, m_rw_rsp, m_rs_rsp}); end
        total++; if ({m_rdy_after, m_v_after} !== 2'b10)
            begin bad++; $display("FAIL status_after_resp: got %b want 10", {m_rdy_after, m_v_after}); end
    endtask

    task automatic test_data_read();
        bus.lcd_data_i = 8'hC1;
        wait_ready();
        issue(1'b1, 1'b0);
        run_txn(1'b1, 100);
        total++; if (m_lat != 55)        begin bad++; $display("FAIL data_latency: got %0d want 55", m_lat); end
        total++; if (m_data !== 8'hC1)   begin bad++; $display("FAIL data_byte: got %h want c1", m_data); end
        total++; if (m_busy !== 1'b0)    begin bad++; $display("FAIL data_busy: got %b want 0", m_busy); end
        total++; if (m_addr !== 7'h00)   begin bad++; $display("FAIL data_addr: got %h want 00", m_addr); end
        total++; if (m_rs_bad != 0)      begin bad++; $display("FAIL data_rs_high: got %0d bad cycles want 0", m_rs_bad); end
        total++; if (m_rs_rsp !== 1'b0)  begin bad++; $display("FAIL data_rs_at_resp: got %b want 0", m_rs_rsp); end
        // Poll flag is meaningless on a data read: one cycle, no timeout.
        bus.lcd_data_i = 8'hFF;
        wait_ready();
        issue(1'b1, 1'b1);
        run_txn(1'b1, 300);
        total++; if (m_pulses != 1)      begin bad++; $display("FAIL data_poll_ignored_pulses: got %0d want 1", m_pulses); end
        total++; if ({m_busy, m_to} !== 2'b00)
            begin bad++; $display("FAIL data_poll_ignored_flags: got %b want 00", {m_busy, m_to}); end
    endtask

    task automatic test_poll_clear();
        pad_seq[0] = 8'h80; pad_seq[1] = 8'h80; pad_seq[2] = 8'h80; pad_seq[3] = 8'h07;
        npad = 4;
        bus.lcd_data_i = 8'h80;
        wait_ready();
        issue(1'b0, 1'b1);
        run_txn(1'b0, 400);
        npad = 0;
        total++; if (m_pulses != 4)      begin bad++; $display("FAIL poll_pulses: got %0d want 4", m_pulses); end
        total++; if (m_lat != 217)       begin bad++; $display("FAIL poll_latency: got %0d want 217", m_lat); end
        total++; if (m_ehigh != 100)     begin bad++; $display("FAIL poll_e_high: got %0d want 100", m_ehigh); end
        total++; if (m_rw_bad != 0)      begin bad++; $display("FAIL poll_rw_held: got %0d bad cycles want 0", m_rw_bad); end
        total++; if ({m_busy, m_addr, m_to} !== {1'b0, 7'h07, 1'b0})
            begin bad++; $display("FAIL poll_result: got %b/%h/%b want 0/07/0", m_busy, m_addr, m_to); end
        total++; if (m_data !== 8'h07)   begin bad++; $display("FAIL poll_data: got %h want 07", m_data); end
    endtask

    task automatic test_poll_timeout();
        bus.lcd_data_i = 8'hFF;
        wait_ready();
        issue(1'b0, 1'b1);
        run_txn(1'b0, 400);
        total++; if (m_pulses != 4)      begin bad++; $display("FAIL timeout_pulses: got %0d want 4", m_pulses); end
        total++; if (m_to !== 1'b1)      begin bad++; $display("FAIL timeout_flag: got %b want 1", m_to); end
        total++; if (m_data !== 8'hFF)   begin bad++; $display("FAIL timeout_data: got %h want ff", m_data); end
        total++; if ({m_busy, m_addr} !== {1'b1, 7'h7F})
            begin bad++; $display("FAIL timeout_status: got %b/%h want 1/7f", m_busy, m_addr); end
        total++; if (m_lat != 217)       begin bad++; $display("FAIL timeout_latency: got %0d want 217", m_lat); end
    endtask

    task automatic test_sample_point();
        // Sample index 20 of E-high falls in cycle 24.
        bus.lcd_data_i = 8'h11; chg_cyc = 25; chg_val = 8'h22;
        wait_ready();
        issue(1'b0, 1'b0);
        run_txn(1'b0, 100);
        total++; if (m_data !== 8'h11)   begin bad++; $display("FAIL sample_late_change: got %h want 11", m_data); end
        bus.lcd_data_i = 8'h11; chg_cyc = 24;
        wait_ready();
        issue(1'b0, 1'b0);
        run_txn(1'b0, 100);
        total++; if (m_data !== 8'h22)   begin bad++; $display("FAIL sample_on_point_change: got %h want 22", m_data); end
        chg_cyc = -1;
    endtask

    task automatic test_ignore_busy();
        int extra;
        bus.lcd_data_i = 8'h3A;
        wait_ready();
        hold_valid = 1'b1;
        issue(1'b0, 1'b0);
        run_txn(1'b0, 100);
        hold_valid = 1'b0;
        total++; if (m_lat != 55 || m_data !== 8'h3A)
            begin bad++; $display("FAIL ignore_txn: got lat %0d data %h want 55/3a", m_lat, m_data); end
        extra = 0;
        for (int i = 0; i < 70; i++) begin
            if (bus.lcd_rw === 1'b1 || bus.rsp_valid === 1'b1) extra++;
            tick();
        end
        total++; if (extra != 0)         begin bad++; $display("FAIL ignore_not_queued: got %0d active cycles want 0", extra); end
    endtask

    task automatic test_reset_mid();
        int extra;
        bus.lcd_data_i = 8'h42;
        wait_ready();
        issue(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        total++; if (bus.lcd_e !== 1'b1) begin bad++; $display("FAIL midrst_e_before: got %b want 1", bus.lcd_e); end
        rst_n = 1'b0;
        tick();
        total++; if ({bus.lcd_e, bus.lcd_rw, bus.rsp_valid} !== 3'b000)
            begin bad++; $display("FAIL midrst_pins: got %b want 000", {bus.lcd_e, bus.lcd_rw, bus.rsp_valid}); end
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 80; i++) begin
            if (bus.rsp_valid === 1'b1 || bus.lcd_e === 1'b1) extra++;
            tick();
        end
        total++; if (extra != 0)         begin bad++; $display("FAIL midrst_abandoned: got %0d cycles want 0", extra); end
        wait_ready();
        issue(1'b0, 1'b0);
        run_txn(1'b0, 100);
        total++; if (m_lat != 55 || m_data !== 8'h42)
            begin bad++; $display("FAIL midrst_recover: got lat %0d data %h want 55/42", m_lat, m_data); end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_rs = 1'b0; bus.req_poll = 1'b0; bus.lcd_data_i = 8'h00;
        test_reset();
        test_status_read();
        test_data_read();
        test_poll_clear();
        test_poll_timeout();
        test_sample_point();
        test_ignore_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
